// File: rtl/calc_sequencer.sv
// Calculator control sequencer: turns key strobes into operand-register pulses
// and runs the start/done handshake with the multi-cycle arithmetic unit.
module calc_sequencer #(
    parameter int unsigned ARITH_TIMEOUT = 64,
    parameter int unsigned CNT_W         = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [4:0] key_code,
    input  logic       arith_done,
    input  logic       arith_ovf,
    output logic       newhex,
    output logic [3:0] hexcode,
    output logic       newop,
    output logic       eq,
    output logic       clear,
    output logic [1:0] op_sel,
    output logic       arith_start,
    output logic       busy,
    output logic       error,
    output logic       key_drop
);

    localparam logic [4:0] KEY_ADD = 5'd16;
    localparam logic [4:0] KEY_EQ  = 5'd19;
    localparam logic [4:0] KEY_CLR = 5'd20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_COMMIT,
        ST_ERROR
    } state_t;

    state_t           state, state_d;
    logic             op_valid, op_valid_d;
    logic             buf_valid, buf_valid_d;
    logic [4:0]       buf_code, buf_code_d;
    logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;

    logic       newhex_d, newop_d, eq_d, clear_d, start_d, busy_d, error_d, key_drop_d;
    logic [3:0] hexcode_d;
    logic [1:0] op_sel_d;

    logic       key_clr, key_ok, store_key, pk_v;
    logic [4:0] pk;

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        op_valid_d  = op_valid;
        buf_valid_d = buf_valid;
        buf_code_d  = buf_code;
        cnt_d       = cnt;
        newhex_d    = 1'b0;
        hexcode_d   = hexcode;
        newop_d     = 1'b0;
        clear_d     = 1'b0;
        op_sel_d    = op_sel;
        key_drop_d  = key_drop;
        store_key   = 1'b0;
        pk_v        = 1'b0;
        pk          = 5'd0;
        cnt_inc     = cnt + CNT_W'(1);

        key_clr = key_valid && (key_code == KEY_CLR);
        key_ok  = key_valid && (key_code < KEY_CLR);

        if (key_clr) begin
            state_d     = ST_IDLE;
            clear_d     = 1'b1;
            op_valid_d  = 1'b0;
            op_sel_d    = 2'b00;
            buf_valid_d = 1'b0;
            key_drop_d  = 1'b0;
            cnt_d       = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A buffered key goes first; a fresh key then takes its slot
                    if (buf_valid) begin
                        pk          = buf_code;
                        pk_v        = 1'b1;
                        buf_valid_d = key_ok;
                        if (key_ok) buf_code_d = key_code;
                    end else begin
                        pk   = key_code;
                        pk_v = key_ok;
                    end
                    if (pk_v) begin
                        if (pk < KEY_ADD) begin
                            newhex_d  = 1'b1;
                            hexcode_d = pk[3:0];
                        end else if (pk < KEY_EQ) begin
                            newop_d    = 1'b1;
                            op_sel_d   = 2'(pk - KEY_ADD);
                            op_valid_d = 1'b1;
                        end else if (op_valid) begin
                            state_d = ST_START;
                        end
                    end
                end
                ST_START: begin
                    cnt_d     = '0;
                    state_d   = ST_WAIT;
                    store_key = 1'b1;
                end
                ST_WAIT: begin
                    cnt_d     = cnt_inc;
                    store_key = 1'b1;
                    if (arith_done) begin
                        state_d = arith_ovf ? ST_ERROR : ST_COMMIT;
                    end else if (cnt_inc == CNT_W'(ARITH_TIMEOUT)) begin
                        state_d = ST_ERROR;
                    end
                end
                ST_COMMIT: begin
                    state_d   = ST_IDLE;
                    store_key = 1'b1;
                end
                default: ;
            endcase

            if (store_key && key_ok) begin
                if (buf_valid) begin
                    key_drop_d = 1'b1;
                end else begin
                    buf_valid_d = 1'b1;
                    buf_code_d  = key_code;
                end
            end
        end

        start_d = (state_d == ST_START);
        eq_d    = (state_d == ST_COMMIT);
        busy_d  = (state_d == ST_START) || (state_d == ST_WAIT) || (state_d == ST_COMMIT);
        error_d = (state_d == ST_ERROR);
    end

    // State and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            op_valid    <= 1'b0;
            buf_valid   <= 1'b0;
            buf_code    <= 5'd0;
            cnt         <= '0;
            newhex      <= 1'b0;
            hexcode     <= 4'd0;
            newop       <= 1'b0;
            eq          <= 1'b0;
            clear       <= 1'b0;
            op_sel      <= 2'b00;
            arith_start <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b0;
            key_drop    <= 1'b0;
        end else begin
            state       <= state_d;
            op_valid    <= op_valid_d;
            buf_valid   <= buf_valid_d;
            buf_code    <= buf_code_d;
            cnt         <= cnt_d;
            newhex      <= newhex_d;
            hexcode     <= hexcode_d;
            newop       <= newop_d;
            eq          <= eq_d;
            clear       <= clear_d;
            op_sel      <= op_sel_d;
            arith_start <= start_d;
            busy        <= busy_d;
            error       <= error_d;
            key_drop    <= key_drop_d;
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_calc_sequencer;

    localparam int TIMEOUT = 8;

    localparam int M_IDLE   = 0;
    localparam int M_START  = 1;
    localparam int M_WAIT   = 2;
    localparam int M_COMMIT = 3;
    localparam int M_ERROR  = 4;

    logic       clock = 1'b1;
    logic       reset;
    logic       key_valid;
    logic [4:0] key_code;
    logic       arith_done;
    logic       arith_ovf;
    logic       newhex;
    logic [3:0] hexcode;
    logic       newop;
    logic       eq;
    logic       clear;
    logic [1:0] op_sel;
    logic       arith_start;
    logic       busy;
    logic       error;
    logic       key_drop;

    int checks = 0;
    int errors = 0;
    bit check_en = 0;

    // Model state
    int         m_mode;
    int         m_wait;
    bit         m_opv;
    int         kbuf[$];
    bit         e_newhex, e_newop, e_clear, e_drop;
    logic [3:0] e_hex;
    logic [1:0] e_op;

    calc_sequencer #(.ARITH_TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
        .clock(clock), .reset(reset),
        .key_valid(key_valid), .key_code(key_code),
        .arith_done(arith_done), .arith_ovf(arith_ovf),
        .newhex(newhex), .hexcode(hexcode), .newop(newop), .eq(eq), .clear(clear),
        .op_sel(op_sel), .arith_start(arith_start), .busy(busy), .error(error),
        .key_drop(key_drop)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [13:0] dut_vec();
        return {newhex, hexcode, newop, eq, clear, op_sel, arith_start, busy, error, key_drop};
    endfunction

    function automatic logic [13:0] exp_vec();
        bit b;
        b = (m_mode == M_START) || (m_mode == M_WAIT) || (m_mode == M_COMMIT);
        return {e_newhex, e_hex, e_newop, (m_mode == M_COMMIT), e_clear, e_op,
                (m_mode == M_START), b, (m_mode == M_ERROR), e_drop};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_wait = 0; m_opv = 0; kbuf.delete();
        e_newhex = 0; e_newop = 0; e_clear = 0; e_drop = 0; e_hex = 4'd0; e_op = 2'd0;
    endtask

    task automatic model_buffer(input bit fresh, input int kc);
        if (fresh) begin
            if (kbuf.size() == 0) kbuf.push_back(kc);
            else e_drop = 1;
        end
    endtask

    task automatic model_step(input bit kv, input int kc, input bit ad, input bit ao);
        bit fresh, have;
        int k;
        fresh = kv && (kc < 20);
        e_newhex = 0; e_newop = 0; e_clear = 0;
        if (kv && kc == 20) begin
            m_mode = M_IDLE; e_clear = 1; m_opv = 0; e_op = 2'd0; kbuf.delete(); e_drop = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    have = fresh; k = kc;
                    if (kbuf.size() != 0) begin
                        k = kbuf.pop_front();
                        have = 1;
                        if (fresh) kbuf.push_back(kc);
                    end
                    if (have) begin
                        if (k < 16) begin e_newhex = 1; e_hex = 4'(k); end
                        else if (k < 19) begin e_newop = 1; e_op = 2'(k - 16); m_opv = 1; end
                        else if (m_opv) m_mode = M_START;
                    end
                end
                M_START: begin m_mode = M_WAIT; m_wait = 0; model_buffer(fresh, kc); end
                M_WAIT: begin
                    m_wait++;
                    if (ad) m_mode = ao ? M_ERROR : M_COMMIT;
                    else if (m_wait >= TIMEOUT) m_mode = M_ERROR;
                    model_buffer(fresh, kc);
                end
                M_COMMIT: begin m_mode = M_IDLE; model_buffer(fresh, kc); end
                default: ;
            endcase
        end
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) model_reset();
        else model_step(key_valid, int'(key_code), arith_done, arith_ovf);
    end

    // Every cycle: all outputs against the model
    always @(negedge clock) begin
        if (check_en) check("outputs", 32'(dut_vec()), 32'(exp_vec()));
    end

    task automatic tick(input bit kv, input int kc, input bit ad, input bit ao);
        key_valid = kv; key_code = 5'(kc); arith_done = ad; arith_ovf = ao;
        @(negedge clock);
    endtask

    initial begin
        int r, kc;
        bit kv;
        reset = 1'b0; key_valid = 0; key_code = 5'd0; arith_done = 0; arith_ovf = 0;
        @(negedge clock);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        check_en = 1;
        check("reset_outputs", 32'(dut_vec()), 32'd0);
        reset = 1'b1;

        // Digits
        tick(1, 3, 0, 0);
        check("d3_newhex", 32'(newhex), 32'd1);
        check("d3_hexcode", 32'(hexcode), 32'd3);
        tick(0, 0, 0, 0);
        check("d3_pulse_end", 32'(newhex), 32'd0);
        tick(1, 7, 0, 0);
        check("d7_hexcode", 32'(hexcode), 32'd7);
        tick(0, 0, 0, 0);
        check("d7_no_other", 32'({newop, eq, clear, arith_start}), 32'd0);

        // Add then equals, then repeated equals
        tick(1, 16, 0, 0);
        check("add_newop", 32'({newop, op_sel}), 32'b100);
        tick(1, 19, 0, 0);
        check("add_start", 32'({arith_start, busy}), 32'b11);
        tick(0, 0, 0, 0);
        check("add_wait", 32'({arith_start, busy}), 32'b01);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 1, 0);
        check("add_eq", 32'({eq, busy}), 32'b11);
        tick(0, 0, 0, 0);
        check("add_idle", 32'({eq, busy}), 32'b00);
        tick(1, 19, 0, 0);
        check("repeat_start", 32'({arith_start, op_sel}), 32'b100);
        tick(0, 0, 0, 0);
        tick(0, 0, 1, 0);
        check("repeat_eq", 32'(eq), 32'd1);
        tick(0, 0, 0, 0);

        // Equals without an operator
        tick(1, 20, 0, 0);
        check("clr_pulse", 32'(clear), 32'd1);
        tick(1, 19, 0, 0);
        check("noop_eq", 32'({arith_start, busy}), 32'd0);
        tick(0, 0, 0, 0);
        check("noop_busy", 32'(busy), 32'd0);

        // Multiply with done withheld -> timeout
        tick(1, 18, 0, 0);
        check("mul_op", 32'({newop, op_sel}), 32'b110);
        tick(1, 19, 0, 0);
        tick(0, 0, 0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) tick(0, 0, 0, 0);
        check("to_last_wait", 32'({busy, error}), 32'b10);
        tick(0, 0, 0, 0);
        check("to_error", 32'({busy, error}), 32'b01);
        tick(1, 5, 0, 0);
        check("err_digit", 32'({newhex, hexcode, error}), 32'b0_0111_1);
        tick(0, 0, 1, 0);
        check("err_done", 32'({eq, error}), 32'b01);
        tick(1, 20, 0, 0);
        check("err_clear", 32'({clear, error, op_sel}), 32'b1000);
        tick(1, 19, 0, 0);
        check("err_opv", 32'(arith_start), 32'd0);

        // Buffered key and dropped key during WAIT
        tick(1, 16, 0, 0);
        tick(1, 19, 0, 0);
        tick(0, 0, 0, 0);
        tick(1, 4, 0, 0);
        tick(1, 9, 0, 0);
        check("buf_drop", 32'(key_drop), 32'd1);
        tick(0, 0, 1, 0);
        check("buf_eq", 32'({eq, newhex}), 32'b10);
        tick(0, 0, 0, 0);
        check("buf_gap", 32'(newhex), 32'd0);
        tick(0, 0, 0, 0);
        check("buf_hex4", 32'({newhex, hexcode, key_drop}), 32'b1_0100_1);
        tick(0, 0, 0, 0);
        check("buf_empty", 32'(newhex), 32'd0);

        // Reset during WAIT
        tick(1, 19, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        #2 reset = 1'b0;
        #1 check("async_reset", 32'(dut_vec()), 32'd0);
        @(negedge clock);
        tick(0, 0, 0, 0);
        reset = 1'b1;
        tick(0, 0, 1, 0);
        check("late_done", 32'({eq, busy}), 32'd0);
        tick(1, 19, 0, 0);
        check("post_reset_eq", 32'(arith_start), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            kv = ($urandom_range(0, 2) == 0);
            r  = $urandom_range(0, 99);
            if (r < 50)      kc = $urandom_range(0, 15);
            else if (r < 70) kc = $urandom_range(16, 18);
            else if (r < 85) kc = 19;
            else if (r < 88) kc = 20;
            else             kc = $urandom_range(21, 31);
            tick(kv, kc, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
        end
        tick(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
